// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-subset control unit.
//   Sequences lw, sw, R-type, addi, beq and j through a Moore FSM and drives
//   the datapath selects and write strobes. Unsupported op/funct pulse illegal.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   op           instruction[31:26]
//   funct        instruction[5:0]
//   zero         ALU result-equals-zero flag
//   alu_control  ALU F code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
//   alu_src_a    0=PC, 1=register A
//   alu_src_b    00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//   pc_src       00=ALU result, 01=ALUOut, 10=jump target
//   iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en
//                datapath strobes/selects
//   illegal      one-cycle pulse on unsupported op or funct
module mc_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_en,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEXE = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     state;
  state_t     state_next;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic       illegal_s;
  logic       pc_write;
  logic       branch;
  logic [2:0] funct_ctl;
  logic       funct_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  always_comb begin
    funct_ctl = 3'b010;
    funct_ok  = 1'b1;
    case (funct)
      6'b100000: funct_ctl = 3'b010;
      6'b100010: funct_ctl = 3'b110;
      6'b100100: funct_ctl = 3'b000;
      6'b100101: funct_ctl = 3'b001;
      6'b101010: funct_ctl = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = FETCH;
    alu_control = 3'b010;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    iord        = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    illegal_s   = 1'b0;
    case (state)
      FETCH: begin
        ir_write_s = 1'b1;
        alu_src_b  = 2'b01;
        pc_write   = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYP:      state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXE;
          OP_J:         state_next = JUMP;
          default:      illegal_s  = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_s = 1'b1;
      end
      MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_ctl;
        illegal_s   = ~funct_ok;
        state_next  = ALUWB;
      end
      ALUWB: begin
        reg_dst     = 1'b1;
        // An unsupported funct already flagged illegal in EXECUTE; drop its write-back.
        reg_write_s = funct_ok;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        pc_src      = 2'b01;
        branch      = 1'b1;
      end
      ADDIEXE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write_s = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Reset holds state at FETCH, whose strobes must not fire while reset is low.
  assign ir_write  = ir_write_s  & reset_n;
  assign mem_write = mem_write_s & reset_n;
  assign reg_write = reg_write_s & reset_n;
  assign illegal   = illegal_s   & reset_n;
  assign pc_en     = (pc_write | (branch & zero)) & reset_n;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed self-checking bench for mc_control.
//   Outputs are packed into one 16-bit vector and compared once per state
//   against hand-written per-state constants.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en, illegal;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // {alu_control, alu_src_a, alu_src_b, pc_src,
  //  iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en, illegal}
  logic [15:0] obs;
  assign obs = {alu_control, alu_src_a, alu_src_b, pc_src,
                iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en, illegal};

  localparam logic [15:0] V_RESET    = {3'b010, 1'b0, 2'b01, 2'b00, 8'b0000_0000};
  localparam logic [15:0] V_FETCH    = {3'b010, 1'b0, 2'b01, 2'b00, 8'b0100_0010};
  localparam logic [15:0] V_DECODE   = {3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0000};
  localparam logic [15:0] V_DEC_ILL  = {3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0001};
  localparam logic [15:0] V_MEMADR   = {3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
  localparam logic [15:0] V_MEMRD    = {3'b010, 1'b0, 2'b00, 2'b00, 8'b1000_0000};
  localparam logic [15:0] V_MEMWB    = {3'b010, 1'b0, 2'b00, 2'b00, 8'b0001_0100};
  localparam logic [15:0] V_MEMWR    = {3'b010, 1'b0, 2'b00, 2'b00, 8'b1010_0000};
  localparam logic [15:0] V_EXE_ILL  = {3'b010, 1'b1, 2'b00, 2'b00, 8'b0000_0001};
  localparam logic [15:0] V_ALUWB    = {3'b010, 1'b0, 2'b00, 2'b00, 8'b0001_1000};
  localparam logic [15:0] V_ALUWB_NW = {3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_1000};
  localparam logic [15:0] V_BR_Z1    = {3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0010};
  localparam logic [15:0] V_BR_Z0    = {3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0000};
  localparam logic [15:0] V_ADDIEXE  = {3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
  localparam logic [15:0] V_ADDIWB   = {3'b010, 1'b0, 2'b00, 2'b00, 8'b0001_0000};
  localparam logic [15:0] V_JUMP     = {3'b010, 1'b0, 2'b00, 2'b10, 8'b0000_0010};

  mc_control dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .alu_control (alu_control),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .iord        (iord),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .pc_en       (pc_en),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0; op = 6'b100011; funct = '0; zero = 1'b1;
    #1; n_cmp++;
    if (obs !== V_RESET) begin n_fail++; $display("FAIL reset_async: got %h want %h", obs, V_RESET); end
    @(posedge clk); #1; n_cmp++;
    if (obs !== V_RESET) begin n_fail++; $display("FAIL reset_held: got %h want %h", obs, V_RESET); end
    @(negedge clk); reset_n = 1'b1;
    #1; n_cmp++;
    if (obs !== V_FETCH) begin n_fail++; $display("FAIL reset_release_fetch: got %h want %h", obs, V_FETCH); end
  endtask

  task automatic test_lw();
    logic [15:0] exp [5];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
    op = 6'b100011; funct = '0; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) op = 6'b111111;   // op is not consulted in MEMRD/MEMWB
      #1; n_cmp++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL lw_cycle%0d: got %h want %h", i, obs, exp[i]); end
      @(negedge clk);
    end
    #1; n_cmp++;
    if (obs !== V_FETCH) begin n_fail++; $display("FAIL lw_end_fetch: got %h want %h", obs, V_FETCH); end
  endtask

  task automatic test_sw();
    logic [15:0] exp [4];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
    op = 6'b101011; funct = '0; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL sw_cycle%0d: got %h want %h", i, obs, exp[i]); end
      @(negedge clk);
    end
    #1; n_cmp++;
    if (obs !== V_FETCH) begin n_fail++; $display("FAIL sw_end_fetch: got %h want %h", obs, V_FETCH); end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [5];
    logic [2:0] ctl [5];
    logic [15:0] exp [4];
    fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ctl = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};
    for (int k = 0; k < 5; k++) begin
      op = 6'b000000; funct = fn[k]; zero = 1'b0;
      exp = '{V_FETCH, V_DECODE, {ctl[k], 1'b1, 2'b00, 2'b00, 8'b0000_0000}, V_ALUWB};
      for (int i = 0; i < 4; i++) begin
        #1; n_cmp++;
        if (obs !== exp[i]) begin
          n_fail++; $display("FAIL rtype_f%b_cycle%0d: got %h want %h", fn[k], i, obs, exp[i]);
        end
        @(negedge clk);
      end
      #1; n_cmp++;
      if (obs !== V_FETCH) begin n_fail++; $display("FAIL rtype_end_fetch: got %h want %h", obs, V_FETCH); end
    end
  endtask

  task automatic test_addi();
    logic [15:0] exp [4];
    exp = '{V_FETCH, V_DECODE, V_ADDIEXE, V_ADDIWB};
    op = 6'b001000; funct = 6'b111111; zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL addi_cycle%0d: got %h want %h", i, obs, exp[i]); end
      @(negedge clk);
    end
    #1; n_cmp++;
    if (obs !== V_FETCH) begin n_fail++; $display("FAIL addi_end_fetch: got %h want %h", obs, V_FETCH); end
  endtask

  task automatic test_beq(input logic z);
    logic [15:0] exp [3];
    exp = '{V_FETCH, V_DECODE, z ? V_BR_Z1 : V_BR_Z0};
    op = 6'b000100; funct = '0; zero = z;
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL beq_z%0b_cycle%0d: got %h want %h", z, i, obs, exp[i]); end
      @(negedge clk);
    end
    #1; n_cmp++;
    if (obs !== V_FETCH) begin n_fail++; $display("FAIL beq_end_fetch: got %h want %h", obs, V_FETCH); end
  endtask

  task automatic test_illegal_op();
    logic [15:0] exp [2];
    exp = '{V_FETCH, V_DEC_ILL};
    op = 6'b111111; funct = 6'b100000; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; n_cmp++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL illop_cycle%0d: got %h want %h", i, obs, exp[i]); end
      @(negedge clk);
    end
    #1; n_cmp++;
    if (obs !== V_FETCH) begin n_fail++; $display("FAIL illop_end_fetch: got %h want %h", obs, V_FETCH); end
  endtask

  task automatic test_reset_mid_sw();
    logic [15:0] exp [4];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
    op = 6'b101011; funct = '0; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL rstmid_cycle%0d: got %h want %h", i, obs, exp[i]); end
      if (i < 3) @(negedge clk);
    end
    reset_n = 1'b0;
    #1; n_cmp++;
    if (obs !== V_RESET) begin n_fail++; $display("FAIL rstmid_abort: got %h want %h", obs, V_RESET); end
    @(posedge clk); #1; n_cmp++;
    if (obs !== V_RESET) begin n_fail++; $display("FAIL rstmid_held: got %h want %h", obs, V_RESET); end
    @(negedge clk); reset_n = 1'b1;
    test_sw();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [7];
    exp = '{V_FETCH, V_DECODE, V_JUMP, V_FETCH, V_DECODE, V_EXE_ILL, V_ALUWB_NW};
    op = 6'b000010; funct = 6'b000000; zero = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) op = 6'b000000;
      #1; n_cmp++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL b2b_cycle%0d: got %h want %h", i, obs, exp[i]); end
      @(negedge clk);
    end
    #1; n_cmp++;
    if (obs !== V_FETCH) begin n_fail++; $display("FAIL b2b_end_fetch: got %h want %h", obs, V_FETCH); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_addi();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal_op();
    test_reset_mid_sw();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
